branch_resolver: RTL and testbench
==================================

// Module: branch_resolver
// PURPOSE
//  Consumer side of the flag register: reads the stored ZCSO flags, evaluates a jump
//  condition code and, if the jump is taken, hands the target address to the PC unit
//  over a valid/ready handshake, then pulses a pipeline flush. It also waits out flag
//  hazards while the flag register has an update pending, and counts taken branches.
// PARAMETERS
//  ADDR_W       16  width of jump target / PC load address
//  TAKEN_CNT_W   8  width of the taken-branch counter (wraps)
// PORTS
//  clock          in   1            system clock, all state on posedge
//  reset          in   1            asynchronous, active-low reset
//  jmp_valid      in   1            decoder presents a jump request
//  jmp_ready      out  1            resolver can accept a request (IDLE only)
//  jmp_cond       in   4            condition code (table below)
//  jmp_target     in   ADDR_W       jump target address
//  ZCSO           in   4            stored flags: [0]=Z [1]=C [2]=S [3]=O
//  flags_busy     in   1            flag register update pending; ZCSO not yet valid
//  pc_load_valid  out  1            target offered to PC unit
//  pc_load_ready  in   1            PC unit accepts target
//  pc_load_addr   out  ADDR_W       captured target, stable while pc_load_valid
//  flush          out  1            1-cycle pulse after PC load handshake
//  resolved       out  1            1-cycle pulse: request finished
//  resolved_taken out  1            valid with resolved: 1=taken, 0=not taken
//  cond_err       out  1            1-cycle pulse in EVAL when jmp_cond=4'b1111
//  taken_count    out  TAKEN_CNT_W  number of completed taken jumps, wraps to 0
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE; jmp_ready=1; pc_load_valid, flush, resolved,
//   resolved_taken, cond_err=0; pc_load_addr=0; taken_count=0; captured cond/target=0.
//   Reset mid-operation abandons the request: no load, no flush, counter cleared.
//  FSM states: IDLE, WAIT_FLAGS, EVAL, ISSUE.
//   IDLE: jmp_ready=1. jmp_valid=1 -> capture jmp_cond, jmp_target; next = flags_busy ?
//     WAIT_FLAGS : EVAL. jmp_ready=0 in every other state.
//   WAIT_FLAGS: hold while flags_busy=1; -> EVAL on first cycle with flags_busy=0.
//   EVAL: sample ZCSO this cycle; compute taken from captured cond.
//     taken -> ISSUE (pc_load_addr <= captured target).
//     not taken -> resolved=1, resolved_taken=0 next cycle, -> IDLE.
//     cond 1111 -> cond_err=1, treated as not taken.
//   ISSUE: pc_load_valid=1, pc_load_addr held. On pc_load_valid&pc_load_ready:
//     next cycle flush=1, resolved=1, resolved_taken=1, taken_count+1 (mod 2^W),
//     pc_load_valid=0, state=IDLE. Stalls indefinitely without pc_load_ready.
//  Latency: accept at edge N, EVAL in cycle N+1, pc_load_valid earliest cycle N+2.
//   New request accepted no earlier than the cycle resolved is high.
//  Condition codes (Z,C,S,O from ZCSO):
//   0000 always   0001 Z        0010 !Z       0011 C        0100 !C
//   0101 S        0110 !S       0111 O        1000 !O       1001 S^O (signed lt)
//   1010 !(S^O)   1011 !Z&!(S^O) 1100 Z|(S^O) 1101 C&!Z     1110 !C|Z
//   1111 illegal -> not taken + cond_err
//  ZCSO is never sampled outside EVAL; changes to ZCSO during ISSUE have no effect.
//  flags_busy is ignored outside IDLE/WAIT_FLAGS.
//  Pulse outputs (flush, resolved, resolved_taken, cond_err) are high exactly 1 cycle.
// TESTING
//  1 reset low mid-ISSUE (pc_load_ready=0) -> pc_load_valid=0, state IDLE, jmp_ready=1,
//    taken_count=0 immediately (async), no flush after release.
//  2 cond=0001, ZCSO=4'b0001, target=16'h1234, flags_busy=0, ready=1 -> pc_load_valid
//    in cycle N+2 with addr 16'h1234, flush+resolved_taken next cycle, taken_count=1.
//  3 cond=0001, ZCSO=4'b0000 -> resolved=1, resolved_taken=0, no pc_load_valid/flush.
//  4 flags_busy=1 for 3 cycles at accept, ZCSO changes 0000->0100 as busy drops,
//    cond=0101 -> EVAL uses new value, jump taken.
//  5 cond=1001 with S=1,O=0 -> taken; S=1,O=1 -> not taken; cond=1111 -> cond_err=1,
//    not taken.
//  6 256 taken jumps with pc_load_ready held low 5 cycles each -> addr stable while
//    valid, taken_count wraps 255->0, jmp_ready=0 throughout ISSUE.

Source files
------------

// File: rtl/branch_resolver.sv
// Jump resolver: waits out pending flag updates, evaluates the condition code against the
// stored ZCSO flags, offers a taken target to the PC unit and pulses flush/resolved.
module branch_resolver #(
    parameter int ADDR_W      = 16,
    parameter int TAKEN_CNT_W = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   jmp_valid,
    output logic                   jmp_ready,
    input  logic [3:0]             jmp_cond,
    input  logic [ADDR_W-1:0]      jmp_target,
    input  logic [3:0]             ZCSO,
    input  logic                   flags_busy,
    output logic                   pc_load_valid,
    input  logic                   pc_load_ready,
    output logic [ADDR_W-1:0]      pc_load_addr,
    output logic                   flush,
    output logic                   resolved,
    output logic                   resolved_taken,
    output logic                   cond_err,
    output logic [TAKEN_CNT_W-1:0] taken_count
);
    typedef enum logic [1:0] {IDLE, WAIT_FLAGS, EVAL, ISSUE} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cond_q, cond_d;
    logic [ADDR_W-1:0]      target_q, target_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   flush_q, flush_d;
    logic                   resolved_q, resolved_d;
    logic                   rtaken_q, rtaken_d;
    logic [TAKEN_CNT_W-1:0] cnt_q, cnt_d;
    logic                   z, c, s, o, lt, taken;

    always_comb begin
        z  = ZCSO[0];
        c  = ZCSO[1];
        s  = ZCSO[2];
        o  = ZCSO[3];
        lt = s ^ o;
        case (cond_q)
            4'h0:    taken = 1'b1;
            4'h1:    taken = z;
            4'h2:    taken = !z;
            4'h3:    taken = c;
            4'h4:    taken = !c;
            4'h5:    taken = s;
            4'h6:    taken = !s;
            4'h7:    taken = o;
            4'h8:    taken = !o;
            4'h9:    taken = lt;
            4'hA:    taken = !lt;
            4'hB:    taken = !z && !lt;
            4'hC:    taken = z || lt;
            4'hD:    taken = c && !z;
            4'hE:    taken = !c || z;
            default: taken = 1'b0; // 1111 is illegal and never jumps
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cond_d     = cond_q;
        target_d   = target_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        flush_d    = 1'b0;
        resolved_d = 1'b0;
        rtaken_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (jmp_valid) begin
                    cond_d   = jmp_cond;
                    target_d = jmp_target;
                    state_d  = flags_busy ? WAIT_FLAGS : EVAL;
                end
            end
            WAIT_FLAGS: begin
                if (!flags_busy) state_d = EVAL;
            end
            EVAL: begin
                if (taken) begin
                    addr_d  = target_q;
                    state_d = ISSUE;
                end else begin
                    resolved_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            ISSUE: begin
                if (pc_load_ready) begin
                    flush_d    = 1'b1;
                    resolved_d = 1'b1;
                    rtaken_d   = 1'b1;
                    cnt_d      = cnt_q + TAKEN_CNT_W'(1);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cond_q     <= '0;
            target_q   <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            flush_q    <= 1'b0;
            resolved_q <= 1'b0;
            rtaken_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cond_q     <= cond_d;
            target_q   <= target_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            resolved_q <= resolved_d;
            rtaken_q   <= rtaken_d;
        end
    end

    assign jmp_ready      = (state_q == IDLE);
    assign pc_load_valid  = (state_q == ISSUE);
    assign pc_load_addr   = addr_q;
    assign flush          = flush_q;
    assign resolved       = resolved_q;
    assign resolved_taken = rtaken_q;
    assign cond_err       = (state_q == EVAL) && (cond_q == 4'hF);
    assign taken_count    = cnt_q;
endmodule

// File: tb/tb_branch_resolver.sv
// Randomized bench for branch_resolver against a transaction-level model of the jump
// conditions, handshake timing and taken counter.
module tb_branch_resolver;
    logic        clock = 1'b0;
    logic        reset;
    logic        jmp_valid, jmp_ready;
    logic [3:0]  jmp_cond;
    logic [15:0] jmp_target;
    logic [3:0]  ZCSO;
    logic        flags_busy;
    logic        pc_load_valid, pc_load_ready;
    logic [15:0] pc_load_addr;
    logic        flush, resolved, resolved_taken, cond_err;
    logic [7:0]  taken_count;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [7:0]  exp_cnt = '0;

    branch_resolver #(.ADDR_W(16), .TAKEN_CNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .jmp_valid(jmp_valid), .jmp_ready(jmp_ready), .jmp_cond(jmp_cond),
        .jmp_target(jmp_target), .ZCSO(ZCSO), .flags_busy(flags_busy),
        .pc_load_valid(pc_load_valid), .pc_load_ready(pc_load_ready),
        .pc_load_addr(pc_load_addr), .flush(flush), .resolved(resolved),
        .resolved_taken(resolved_taken), .cond_err(cond_err), .taken_count(taken_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: condition semantics stated in terms of flag meaning.
    function automatic bit model_taken(input logic [3:0] cond, input logic [3:0] f);
        bit zf = f[0], cf = f[1], sf = f[2], of = f[3];
        bit less = (sf != of);
        case (cond)
            4'd0:  return 1;
            4'd1:  return zf;
            4'd2:  return !zf;
            4'd3:  return cf;
            4'd4:  return !cf;
            4'd5:  return sf;
            4'd6:  return !sf;
            4'd7:  return of;
            4'd8:  return !of;
            4'd9:  return less;
            4'd10: return !less;
            4'd11: return !(zf || less);
            4'd12: return zf || less;
            4'd13: return cf && !zf;
            4'd14: return !(cf && !zf);
            default: return 0;
        endcase
    endfunction

    // One jump request: k busy cycles from accept, d stall cycles on pc_load_ready.
    // With abort set, reset is pulled mid-ISSUE.
    task automatic do_jump(input logic [3:0] cond, input logic [15:0] tgt, input logic [3:0] z,
                           input logic [3:0] pre_z, input int k, input int d, input bit abort);
        bit tk = model_taken(cond, z);
        @(posedge clock); #1;
        jmp_valid  = 1'b1;
        jmp_cond   = cond;
        jmp_target = tgt;
        flags_busy = (k > 0);
        ZCSO       = (k > 0) ? pre_z : z;
        @(negedge clock);
        check("accept_ready", jmp_ready, 1);
        check("idle_flush", flush, 0);
        check("idle_resolved", resolved, 0);
        @(posedge clock); #1;
        jmp_valid  = 1'b0;
        jmp_cond   = 4'($urandom);
        jmp_target = 16'($urandom);
        for (int i = 1; i <= k; i++) begin
            flags_busy = (i < k);
            if (i == k) ZCSO = z;
            @(negedge clock);
            check("wait_ready", jmp_ready, 0);
            check("wait_valid", pc_load_valid, 0);
            @(posedge clock); #1;
        end
        // EVAL cycle
        @(negedge clock);
        check("eval_cond_err", cond_err, (cond == 4'hF));
        check("eval_valid", pc_load_valid, 0);
        check("eval_ready", jmp_ready, 0);
        @(posedge clock); #1;
        ZCSO       = 4'($urandom);
        flags_busy = 1'($urandom);
        if (!tk) begin
            @(negedge clock);
            check("nt_resolved", resolved, 1);
            check("nt_rtaken", resolved_taken, 0);
            check("nt_flush", flush, 0);
            check("nt_valid", pc_load_valid, 0);
            check("nt_cond_err", cond_err, 0);
            check("nt_ready", jmp_ready, 1);
            check("nt_count", taken_count, exp_cnt);
            flags_busy = 1'b0;
            return;
        end
        for (int j = 0; j <= d; j++) begin
            if (abort && j == 2) begin
                reset = 1'b0;
                #1;
                exp_cnt = '0;
                check("rst_valid", pc_load_valid, 0);
                check("rst_ready", jmp_ready, 1);
                check("rst_count", taken_count, 0);
                check("rst_addr", pc_load_addr, 0);
                @(posedge clock); #1;
                reset = 1'b1;
                flags_busy = 1'b0;
                for (int m = 0; m < 3; m++) begin
                    pc_load_ready = 1'b1;
                    @(negedge clock);
                    check("post_rst_flush", flush, 0);
                    check("post_rst_valid", pc_load_valid, 0);
                    check("post_rst_ready", jmp_ready, 1);
                    @(posedge clock); #1;
                end
                pc_load_ready = 1'b0;
                return;
            end
            pc_load_ready = (j == d);
            @(negedge clock);
            check("issue_valid", pc_load_valid, 1);
            check("issue_addr", pc_load_addr, tgt);
            check("issue_ready", jmp_ready, 0);
            check("issue_flush", flush, 0);
            @(posedge clock); #1;
            ZCSO = 4'($urandom);
        end
        pc_load_ready = 1'b0;
        exp_cnt++;
        @(negedge clock);
        check("tk_flush", flush, 1);
        check("tk_resolved", resolved, 1);
        check("tk_rtaken", resolved_taken, 1);
        check("tk_valid", pc_load_valid, 0);
        check("tk_count", taken_count, exp_cnt);
        check("tk_ready", jmp_ready, 1);
        flags_busy = 1'b0;
    endtask

    initial begin
        reset = 1'b0; jmp_valid = 0; jmp_cond = 0; jmp_target = 0;
        ZCSO = 0; flags_busy = 0; pc_load_ready = 0;
        #12;
        check("rst_jmp_ready", jmp_ready, 1);
        check("rst_pc_valid", pc_load_valid, 0);
        check("rst_pulses", {flush, resolved, resolved_taken, cond_err}, 0);
        check("rst_pc_addr", pc_load_addr, 0);
        check("rst_taken_count", taken_count, 0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Directed cases
        do_jump(4'h1, 16'h1234, 4'b0001, 4'b0000, 0, 0, 0);
        do_jump(4'h1, 16'h5555, 4'b0000, 4'b0000, 0, 0, 0);
        do_jump(4'h5, 16'hBEEF, 4'b0100, 4'b0000, 3, 1, 0);
        do_jump(4'h9, 16'h0A0A, 4'b0100, 4'b0000, 0, 0, 0);
        do_jump(4'h9, 16'h0B0B, 4'b1100, 4'b0000, 0, 0, 0);
        do_jump(4'hF, 16'h0C0C, 4'b1111, 4'b0000, 1, 0, 0);
        do_jump(4'h0, 16'h7777, 4'b0000, 4'b0000, 0, 6, 1);   // reset mid-ISSUE

        // Random mix
        for (int n = 0; n < 200; n++)
            do_jump(4'($urandom), 16'($urandom), 4'($urandom), 4'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);

        // Counter wrap: 256 taken jumps with a 5-cycle stall each
        for (int n = 0; n < 256; n++)
            do_jump(4'h0, 16'($urandom), 4'($urandom), 4'($urandom), 0, 5, 0);

        repeat (2) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
